// File: rtl/text_console.sv
// Byte-stream text console: interprets control codes, tracks a 30x17 cursor, writes char+attr words to VRAM.
// Latency: 1 cycle accept->write; clear takes 1024 cycles. Backpressure: chr_ready_o low outside IDLE.
module text_console #(
  parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  chr_i,
  input  logic [7:0]  attr_i,
  input  logic        chr_valid_i,
  output logic        chr_ready_o,
  output logic        vram_cea_o,
  output logic [9:0]  vram_ada_o,
  output logic [15:0] vram_din_o,
  output logic [4:0]  cur_row_o,
  output logic [4:0]  cur_col_o
);

  typedef enum logic [1:0] {S_CLEAR, S_DONE, S_IDLE} state_t;

  state_t      state;
  logic [9:0]  clr_cnt;
  logic [7:0]  clr_attr;
  logic        accept;
  logic [4:0]  row_inc;
  logic [4:0]  adv_row;
  logic [4:0]  adv_col;

  assign accept = chr_valid_i & chr_ready_o;

  // Row wraps 16 -> 0; there is no scrolling.
  always_comb begin
    row_inc = (cur_row_o == 5'd16) ? 5'd0 : cur_row_o + 5'd1;
    adv_row = cur_row_o;
    adv_col = cur_col_o + 5'd1;
    if (cur_col_o == 5'd29) begin
      adv_col = 5'd0;
      adv_row = row_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_CLEAR;
      clr_cnt     <= 10'd0;
      clr_attr    <= CLEAR_ATTR;
      chr_ready_o <= 1'b0;
      vram_cea_o  <= 1'b0;
      vram_ada_o  <= 10'd0;
      vram_din_o  <= 16'd0;
      cur_row_o   <= 5'd0;
      cur_col_o   <= 5'd0;
    end else begin
      vram_cea_o <= 1'b0;
      case (state)
        S_CLEAR: begin
          vram_cea_o <= 1'b1;
          vram_ada_o <= clr_cnt;
          vram_din_o <= {clr_attr, 8'h20};
          if (clr_cnt == 10'd1023) state <= S_DONE;
          else                     clr_cnt <= clr_cnt + 10'd1;
        end
        S_DONE: begin
          chr_ready_o <= 1'b1;
          clr_cnt     <= 10'd0;
          state       <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            if (chr_i == 8'h0C) begin
              // Address 0 is issued right away so the clear starts the next cycle.
              vram_cea_o  <= 1'b1;
              vram_ada_o  <= 10'd0;
              vram_din_o  <= {attr_i, 8'h20};
              clr_cnt     <= 10'd1;
              clr_attr    <= attr_i;
              cur_row_o   <= 5'd0;
              cur_col_o   <= 5'd0;
              chr_ready_o <= 1'b0;
              state       <= S_CLEAR;
            end else if (chr_i[7:5] != 3'b000) begin
              vram_cea_o <= 1'b1;
              vram_ada_o <= {cur_row_o, cur_col_o};
              vram_din_o <= {attr_i, chr_i};
              cur_row_o  <= adv_row;
              cur_col_o  <= adv_col;
            end else begin
              case (chr_i)
                8'h0D: cur_col_o <= 5'd0;
                8'h0A: cur_row_o <= row_inc;
                8'h08: if (cur_col_o != 5'd0) cur_col_o <= cur_col_o - 5'd1;
                default: ;
              endcase
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: power-on clear, printing, wrap, control codes, form feed, reset mid-clear.
module tb_text_console;

  logic        clk;
  logic        rst_n;
  logic [7:0]  chr;
  logic [7:0]  attr;
  logic        valid;
  logic        ready;
  logic        cea;
  logic [9:0]  ada;
  logic [15:0] din;
  logic [4:0]  row;
  logic [4:0]  col;

  int pass_cnt = 0;
  int total    = 0;

  text_console #(.CLEAR_ATTR(8'h07)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .chr_i       (chr),
    .attr_i      (attr),
    .chr_valid_i (valid),
    .chr_ready_o (ready),
    .vram_cea_o  (cea),
    .vram_ada_o  (ada),
    .vram_din_o  (din),
    .cur_row_o   (row),
    .cur_col_o   (col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    chr   = c;
    attr  = a;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " cea"},   {31'd0, cea},   32'd0);
    chk({tag, " ada"},   {22'd0, ada},   32'd0);
    chk({tag, " din"},   {16'd0, din},   32'd0);
    chk({tag, " ready"}, {31'd0, ready}, 32'd0);
    chk({tag, " row"},   {27'd0, row},   32'd0);
    chk({tag, " col"},   {27'd0, col},   32'd0);
  endtask

  // Follows a clear until ready rises; start is the number of writes already seen.
  task automatic watch_clear(input string tag, input logic [15:0] exp_din, input int start);
    int nwr  = start;
    int bad  = 0;
    int last = -1;
    int rdy  = -100;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (cea === 1'b1) begin
        if (ada !== nwr[9:0] || din !== exp_din || ready !== 1'b0 || row !== 5'd0 || col !== 5'd0)
          bad++;
        nwr++;
        last = i;
      end
      if (ready === 1'b1) begin
        rdy = i;
        break;
      end
    end
    chk({tag, " write count"}, nwr, 32'd1024);
    chk({tag, " bad writes"},  bad, 32'd0);
    chk({tag, " ready gap"},   rdy - last, 32'd1);
  endtask

  initial begin
    int bad;
    int seen;
    rst_n = 1'b0;
    valid = 1'b1;
    chr   = 8'h5A;
    attr  = 8'h07;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Power-on clear with valid held high; 'Z' is taken right after it.
    rst_n = 1'b1;
    watch_clear("poweron", 16'h0720, 0);
    @(negedge clk);
    valid = 1'b0;
    chk("first accept cea", {31'd0, cea}, 32'd1);
    chk("first accept ada", {22'd0, ada}, 32'd0);
    chk("first accept din", {16'd0, din}, 32'h075A);
    chk("first accept col", {27'd0, col}, 32'd1);

    // Printable stream, back to back.
    send(8'h0D, 8'h00);
    chk("cr col", {27'd0, col}, 32'd0);
    chk("cr no write", {31'd0, cea}, 32'd0);
    send(8'h41, 8'h1F);
    chk("A cea", {31'd0, cea}, 32'd1);
    chk("A ada", {22'd0, ada}, 32'h000);
    chk("A din", {16'd0, din}, 32'h1F41);
    send(8'h42, 8'h1F);
    chk("B cea", {31'd0, cea}, 32'd1);
    chk("B ada", {22'd0, ada}, 32'h001);
    chk("B din", {16'd0, din}, 32'h1F42);
    chk("AB row", {27'd0, row}, 32'd0);
    chk("AB col", {27'd0, col}, 32'd2);
    @(negedge clk);
    chk("idle cea", {31'd0, cea}, 32'd0);

    // Line wrap: 30 bytes from (0,0).
    send(8'h0D, 8'h00);
    for (int k = 0; k < 30; k++) send(8'h30 + k[7:0], 8'h07);
    chk("wrap ada", {22'd0, ada}, 32'h01D);
    chk("wrap din", {16'd0, din}, 32'h074D);
    chk("wrap row", {27'd0, row}, 32'd1);
    chk("wrap col", {27'd0, col}, 32'd0);
    send(8'h21, 8'h07);
    chk("next ada", {22'd0, ada}, 32'h020);
    chk("next col", {27'd0, col}, 32'd1);

    // Row wrap from (16,5).
    for (int k = 0; k < 15; k++) send(8'h0A, 8'h00);
    chk("lf col kept", {27'd0, col}, 32'd1);
    send(8'h0D, 8'h00);
    for (int k = 0; k < 5; k++) send(8'h2E, 8'h07);
    chk("pre row", {27'd0, row}, 32'd16);
    chk("pre col", {27'd0, col}, 32'd5);
    send(8'h0A, 8'h00);
    chk("lf wrap row", {27'd0, row}, 32'd0);
    chk("lf wrap col", {27'd0, col}, 32'd5);
    chk("lf no write", {31'd0, cea}, 32'd0);
    send(8'h0D, 8'h00);
    send(8'h08, 8'h00);
    chk("cr bs row", {27'd0, row}, 32'd0);
    chk("bs at col0", {27'd0, col}, 32'd0);
    chk("bs no write", {31'd0, cea}, 32'd0);
    for (int k = 0; k < 3; k++) send(8'h0A, 8'h00);
    for (int k = 0; k < 7; k++) send(8'h2E, 8'h07);
    send(8'h08, 8'h00);
    chk("bs row", {27'd0, row}, 32'd3);
    chk("bs col", {27'd0, col}, 32'd6);

    // Form feed at (5,9).
    for (int k = 0; k < 2; k++) send(8'h0A, 8'h00);
    for (int k = 0; k < 3; k++) send(8'h2E, 8'h07);
    chk("ff pre row", {27'd0, row}, 32'd5);
    chk("ff pre col", {27'd0, col}, 32'd9);
    send(8'h0C, 8'h40);
    chk("ff cea", {31'd0, cea}, 32'd1);
    chk("ff ada", {22'd0, ada}, 32'd0);
    chk("ff din", {16'd0, din}, 32'h4020);
    chk("ff ready", {31'd0, ready}, 32'd0);
    chk("ff home row", {27'd0, row}, 32'd0);
    chk("ff home col", {27'd0, col}, 32'd0);
    watch_clear("ff", 16'h4020, 1);
    bad = 0;
    for (int k = 1; k < 8; k++) begin
      send(k[7:0], 8'h07);
      if (cea !== 1'b0 || row !== 5'd0 || col !== 5'd0 || ready !== 1'b1) bad++;
    end
    chk("ctrl no effect", bad, 32'd0);

    // Reset in the middle of a clear.
    send(8'h0C, 8'h55);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cea === 1'b1 && ada === 10'd300) begin
        seen = 1;
        break;
      end
    end
    chk("reached write 300", seen, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midclear reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart cea", {31'd0, cea}, 32'd1);
    chk("restart ada", {22'd0, ada}, 32'd0);
    chk("restart din", {16'd0, din}, 32'h0720);
    watch_clear("restart", 16'h0720, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/text_console.md
# text_console

Character-stream front end for the `video` text display. It accepts a byte stream over a valid/ready handshake, interprets control codes, and keeps a cursor on the 30x17 text grid. It writes 16-bit character+attribute words into VRAM port A, driving `vram_cea_i`, `vram_ada_i` and `vram_din_i` of `video`. Its clock also drives `vram_clk_i`.

## Interface
- `CLEAR_ATTR`, default 8'h07: attribute used by the power-on clear (black background, grey foreground).
- `clk_i`  in  1  single clock; also drives the VRAM write clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `chr_i`  in  8  incoming byte.
- `attr_i`  in  8  attribute {blink, bg irgb[2:0], fg irgb}, sampled with `chr_i`; bit 7 becomes word bit 15.
- `chr_valid_i`  in  1  byte present.
- `chr_ready_o`  out  1  block can accept a byte this cycle.
- `vram_cea_o`  out  1  VRAM write enable, one-cycle pulse per word.
- `vram_ada_o`  out  10  VRAM address {row[4:0], col[4:0]}.
- `vram_din_o`  out  16  {attr[7:0], chr[7:0]}.
- `cur_row_o`  out  5  cursor row, 0..16.
- `cur_col_o`  out  5  cursor column, 0..29.

## Operation
- Accept: a byte is taken on a rising edge where `chr_valid_i & chr_ready_o`. `chr_ready_o` is high only in IDLE.
- States and transitions:
  - RESET/CLEAR: on reset release, go to CLEAR. CLEAR writes all 1024 addresses 0..1023 with {CLEAR_ATTR, 8'h20}, then goes to IDLE.
  - IDLE: processes one accepted byte per cycle.
  - FF: byte 0x0C in IDLE enters CLEAR. This CLEAR uses the `attr_i` captured with the 0x0C byte, then homes the cursor to (0,0).
- Byte handling in IDLE:
  - 0x20..0x7F printable: write {attr_i, chr_i} at {cur_row, cur_col}, then advance the cursor.
  - 0x80..0xFF: written as printable. `video` uses bits 6:0.
  - 0x0D CR: cur_col := 0. No write.
  - 0x0A LF: cur_row := row+1 with wrap; column unchanged. No write.
  - 0x08 BS: if cur_col > 0, cur_col := cur_col-1. At column 0, no effect. No write, no erase.
  - Other codes below 0x20: consumed, no effect.
- Cursor advance:
  - col 0..28 → col+1.
  - col 29 → col 0, row+1.
  - row 16 +1 → row 0 (wrap, no scrolling).
- Columns 30/31 are never written by printable bytes, only by CLEAR.
- Arithmetic: row and col are 5-bit registers with explicit compares against 29 and 16, never free-running overflow. The CLEAR address counter is 10-bit and terminates when it reaches 1023.
- Reset mid-operation: asserting `rst_n_i` at any time, including mid-CLEAR, immediately returns all outputs to their reset values. After release, a full power-on CLEAR restarts from address 0.
- Reset values:
  - `vram_cea_o` = 0, `vram_ada_o` = 0, `vram_din_o` = 0.
  - `chr_ready_o` = 0.
  - `cur_row_o` = 0, `cur_col_o` = 0.
  - State = CLEAR-pending, clear counter = 0.

## Timing
- All outputs are registered.
- Printable byte accepted at edge N:
  - `vram_cea_o` = 1 with address/data valid during cycle N+1 (written at edge N+1).
  - `cur_*_o` show the advanced cursor after edge N.
- Throughput is one byte per clock. Back-to-back printable bytes produce consecutive write pulses (cea held high).
- CLEAR:
  - Cycle after entry: `chr_ready_o` = 0.
  - `vram_cea_o` = 1 for exactly 1024 consecutive cycles, addresses 0,1,…,1023.
  - `chr_ready_o` returns high the cycle after the last write.
  - Power-on clear begins on the first edge after reset release.
- A 0x0C accept at edge N:
  - First clear write is in cycle N+1.
  - `chr_ready_o` is low from cycle N+1.
  - Cursor reads (0,0) from cycle N+1.
- Control bytes produce no write pulse. Their cursor update is visible after the accepting edge.
- `vram_cea_o` is never asserted in a cycle without a write. Data is undefined when cea = 0 but holds its last value.

## Test plan
- Power-on:
  - Stimulus: release reset, hold `chr_valid_i` = 1.
  - Required response: exactly 1024 writes of 16'h0720 to addresses 0..1023; `chr_ready_o` low throughout; first accept on the cycle after write 1023.
- Printable stream:
  - Stimulus: 'A','B' with attr 8'h1F after clear.
  - Required response: writes (0x000, 16'h1F41), (0x001, 16'h1F42) on consecutive cycles; cursor ends at (0,2).
- Line wrap:
  - Stimulus: 30 printable bytes from (0,0).
  - Required response: last write at address 0x01D; cursor (1,0). Next byte is written to 0x020.
- Row wrap and controls:
  - Stimulus 1: from (16,5), send LF → required response: cursor (0,5), no write.
  - Stimulus 2: then CR, BS → required response: cursor (0,0), no write.
  - Stimulus 3: at (3,7) send BS → required response: (3,6).
- Form feed:
  - Stimulus: 0x0C with attr 8'h40 at cursor (5,9).
  - Required response: 1024 writes of 16'h4020; cursor (0,0); bytes 0x01..0x07 afterwards have no effect.
- Reset mid-clear:
  - Stimulus: assert `rst_n_i` after write 300 of a CLEAR.
  - Required response: outputs go to zero immediately; after release, the clear restarts at address 0 with CLEAR_ATTR.
